// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync
// Single-clock FIFO with valid/ready handshakes on both sides. It buffers
// stream beats between interface components and provides occupancy count,
// almost-full/almost-empty flags, a synchronous flush and an optional
// registered read stage.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst_n        - asynchronous active-low reset
//   flush        - synchronous clear of all contents
//   s_valid      - write-side beat valid
//   s_ready      - write-side ready (not full, not flushing, out of reset)
//   s_data       - write data
//   m_valid      - read-side beat valid
//   m_ready      - read-side consumer ready
//   m_data       - read data
//   count        - words held, 0..DEPTH+OUTREG
//   almost_full  - count >= AF_THRESH
//   almost_empty - count <= AE_THRESH
module stream_fifo_sync #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int OUTREG    = 0,
  parameter int AF_THRESH = (1 << ADDRSIZE) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATASIZE-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [ADDRSIZE:0]   count,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] LP_ONE = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [31:0] LP_AF = AF_THRESH;
  localparam logic [31:0] LP_AE = AE_THRESH;

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE:0]   r_wptr;
  logic [ADDRSIZE:0]   r_rptr;
  logic [ADDRSIZE:0]   r_count;
  logic                r_rdy_en;

  logic w_mem_empty;
  logic w_mem_full;
  logic w_push;
  logic w_pop;
  logic w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_mem_empty = (r_wptr == r_rptr);
  assign w_mem_full  = (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]) &&
                       (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]);

  // r_rdy_en holds s_ready low during reset and until the first edge after
  // release. Readiness depends only on registered state, so a pop never frees
  // a slot for a push in the same cycle.
  assign s_ready = r_rdy_en && !w_mem_full && !flush;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = m_valid && m_ready;

  generate
    if (OUTREG == 0) begin : g_comb_out
      assign m_valid = !w_mem_empty && !flush;
      assign m_data  = r_mem[r_rptr[ADDRSIZE-1:0]];
      assign w_rd    = w_pop;
    end else begin : g_reg_out
      logic [DATASIZE-1:0] r_dreg;
      logic                r_dvalid;

      // Refill the output register whenever it is empty or being drained.
      assign w_rd    = !w_mem_empty && (!r_dvalid || w_pop);
      assign m_valid = r_dvalid && !flush;
      assign m_data  = r_dreg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dvalid <= 1'b0;
        end else if (flush) begin
          r_dvalid <= 1'b0;
        end else if (w_rd) begin
          r_dvalid <= 1'b1;
        end else if (w_pop) begin
          r_dvalid <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (w_rd && !flush) begin
          r_dreg <= r_mem[r_rptr[ADDRSIZE-1:0]];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[ADDRSIZE-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + LP_ONE;
        end
        if (w_rd) begin
          r_rptr <= r_rptr + LP_ONE;
        end
        // A move from memory into the output register does not change count;
        // only beats entering or leaving the FIFO do.
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + LP_ONE;
          2'b01:   r_count <= r_count - LP_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign count        = r_count;
  assign almost_full  = (32'(r_count) >= LP_AF);
  assign almost_empty = (32'(r_count) <= LP_AE);

endmodule
